// File: rtl/koa_mult_128_pipe.sv
// -----------------------------------------------------------------------------
// koa_mult_128_pipe
//
// Purpose:
//   128x128 unsigned multiplier built as a single level of Karatsuba-Ofman
//   (three 64/65-bit sub-products). It also produces the GF(2^128) reduction
//   of the same 256-bit product, modulo x^128 + x^7 + x^2 + x + 1. It is the
//   datapath core of the GF128/GHASH path. The pipeline is three stages deep
//   and accepts one operand pair every clock, with no backpressure.
//
// Ports:
//   clk        in   1    single clock; all state updates on the rising edge
//   rst_n      in   1    synchronous, active-low reset; clears every register
//   in_valid   in   1    a/b carry an operation this cycle
//   a          in   128  operand A, unsigned
//   b          in   128  operand B, unsigned
//   out_valid  out  1    product/reduced carry a result this cycle
//   product    out  256  a*b, exact unsigned integer product
//   reduced    out  128  product viewed as a GF(2) polynomial, mod the GCM poly
//
// Timing:
//   An operation sampled at edge N appears with out_valid=1 during the cycle
//   after edge N+2. During bubbles, out_valid is 0 and the data outputs hold
//   their last value. A reset drops every operation that is in flight.
// -----------------------------------------------------------------------------
module koa_mult_128_pipe #(
  parameter int DATA_WIDTH = 128,
  parameter int LATENCY    = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic [DATA_WIDTH-1:0]   a,
  input  logic [DATA_WIDTH-1:0]   b,
  output logic                    out_valid,
  output logic [2*DATA_WIDTH-1:0] product,
  output logic [DATA_WIDTH-1:0]   reduced
);

  localparam int HALF = DATA_WIDTH / 2;

  // GF(2^128) reduction of a 256-bit carry-less view of the product.
  // The high half H stands for H*x^128, which is congruent to H*(x^7+x^2+x+1).
  // The shifted copies of H spill up to 7 bits past bit 127. That spill (O)
  // is folded a second time. O has degree <= 6, so the second fold cannot
  // overflow again.
  function automatic logic [127:0] gf128_reduce(input logic [255:0] p);
    logic [127:0] h;
    logic [127:0] t;
    logic [127:0] o;
    h = p[255:128];
    t = p[127:0] ^ h ^ (h << 7'd1) ^ (h << 7'd2) ^ (h << 7'd7);
    o = (h >> 7'd127) ^ (h >> 7'd126) ^ (h >> 7'd121);
    return t ^ o ^ (o << 7'd1) ^ (o << 7'd2) ^ (o << 7'd7);
  endfunction

  // ---------------------------------------------------------------------------
  // Stage valid bits: bit 0 = stage 1 (split), bit 1 = stage 2 (sub-products),
  // bit LATENCY-1 = output register. The pipeline depth is fixed at three.
  // ---------------------------------------------------------------------------
  logic [LATENCY-1:0] valid_q;
  logic [LATENCY-1:0] valid_d;

  // Stage 1 registers: operand halves and the two 65-bit half sums.
  logic [HALF-1:0] ah_q, al_q, bh_q, bl_q;
  logic [HALF-1:0] ah_d, al_d, bh_d, bl_d;
  logic [HALF:0]   sa_q, sb_q;
  logic [HALF:0]   sa_d, sb_d;

  // Stage 2 registers: the three Karatsuba sub-products.
  logic [DATA_WIDTH-1:0] z2_q, z0_q;
  logic [DATA_WIDTH-1:0] z2_d, z0_d;
  logic [DATA_WIDTH+1:0] z1_q;
  logic [DATA_WIDTH+1:0] z1_d;

  // Stage 3 (output) registers.
  logic [2*DATA_WIDTH-1:0] product_q;
  logic [2*DATA_WIDTH-1:0] product_d;
  logic [DATA_WIDTH-1:0]   reduced_q;
  logic [DATA_WIDTH-1:0]   reduced_d;

  // Combine-stage intermediates.
  logic [DATA_WIDTH+1:0]   mid_s;
  logic [2*DATA_WIDTH-1:0] product_s;

  // Valid shift chain: each stage inherits the valid bit of the stage before.
  always_comb begin
    valid_d = {valid_q[LATENCY-2:0], in_valid};
  end

  // Stage 1 next state: split the operands and form the half sums.
  // These registers load only on a valid op, so bubbles never disturb them.
  always_comb begin
    ah_d = ah_q;
    al_d = al_q;
    bh_d = bh_q;
    bl_d = bl_q;
    sa_d = sa_q;
    sb_d = sb_q;
    if (in_valid) begin
      ah_d = a[DATA_WIDTH-1:HALF];
      al_d = a[HALF-1:0];
      bh_d = b[DATA_WIDTH-1:HALF];
      bl_d = b[HALF-1:0];
      sa_d = {1'b0, a[DATA_WIDTH-1:HALF]} + {1'b0, a[HALF-1:0]};
      sb_d = {1'b0, b[DATA_WIDTH-1:HALF]} + {1'b0, b[HALF-1:0]};
    end else begin
      ah_d = ah_q;
      al_d = al_q;
      bh_d = bh_q;
      bl_d = bl_q;
      sa_d = sa_q;
      sb_d = sb_q;
    end
  end

  // Stage 2 next state: the three sub-products, zero-extended to full width.
  always_comb begin
    z2_d = z2_q;
    z0_d = z0_q;
    z1_d = z1_q;
    if (valid_q[0]) begin
      z2_d = {{HALF{1'b0}}, ah_q} * {{HALF{1'b0}}, bh_q};
      z0_d = {{HALF{1'b0}}, al_q} * {{HALF{1'b0}}, bl_q};
      z1_d = {{(HALF+1){1'b0}}, sa_q} * {{(HALF+1){1'b0}}, sb_q};
    end else begin
      z2_d = z2_q;
      z0_d = z0_q;
      z1_d = z1_q;
    end
  end

  // Combine: mid = z1 - z2 - z0 equals aH*bL + aL*bH, so it is never negative.
  // Its true value fits in 129 bits. The 130-bit container keeps the
  // subtraction width-consistent, and its top bit is always zero.
  always_comb begin
    mid_s     = z1_q - {2'b00, z2_q} - {2'b00, z0_q};
    product_s = {z2_q, {DATA_WIDTH{1'b0}}}
              + {{(DATA_WIDTH-HALF-2){1'b0}}, mid_s, {HALF{1'b0}}}
              + {{DATA_WIDTH{1'b0}}, z0_q};
  end

  // Stage 3 next state: latch the product and its GF(2^128) reduction.
  // On a bubble, the previous result is held.
  always_comb begin
    product_d = product_q;
    reduced_d = reduced_q;
    if (valid_q[1]) begin
      product_d = product_s;
      reduced_d = gf128_reduce(product_s);
    end else begin
      product_d = product_q;
      reduced_d = reduced_q;
    end
  end

  // Pipeline registers with synchronous active-low clear.
  // A reset drops every operation that is in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q   <= {LATENCY{1'b0}};
      ah_q      <= {HALF{1'b0}};
      al_q      <= {HALF{1'b0}};
      bh_q      <= {HALF{1'b0}};
      bl_q      <= {HALF{1'b0}};
      sa_q      <= {(HALF+1){1'b0}};
      sb_q      <= {(HALF+1){1'b0}};
      z2_q      <= {DATA_WIDTH{1'b0}};
      z0_q      <= {DATA_WIDTH{1'b0}};
      z1_q      <= {(DATA_WIDTH+2){1'b0}};
      product_q <= {(2*DATA_WIDTH){1'b0}};
      reduced_q <= {DATA_WIDTH{1'b0}};
    end else begin
      valid_q   <= valid_d;
      ah_q      <= ah_d;
      al_q      <= al_d;
      bh_q      <= bh_d;
      bl_q      <= bl_d;
      sa_q      <= sa_d;
      sb_q      <= sb_d;
      z2_q      <= z2_d;
      z0_q      <= z0_d;
      z1_q      <= z1_d;
      product_q <= product_d;
      reduced_q <= reduced_d;
    end
  end

  assign out_valid = valid_q[LATENCY-1];
  assign product   = product_q;
  assign reduced   = reduced_q;

endmodule

// File: tb/tb_koa_mult_128_pipe.sv
// -----------------------------------------------------------------------------
// Scoreboard bench for koa_mult_128_pipe.
// The stimulus pushes the expected {product, reduced, due cycle} for each op.
// The monitor samples on the falling edge and pops and compares whenever
// out_valid is high. It also checks the reset-zero state and the held outputs
// during bubbles. The reference reduction is a plain polynomial long division.
// -----------------------------------------------------------------------------
module tb_koa_mult_128_pipe;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [127:0] a;
  logic [127:0] b;
  logic         out_valid;
  logic [255:0] product;
  logic [127:0] reduced;

  always #5 clk = ~clk;

  koa_mult_128_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .product   (product),
    .reduced   (reduced)
  );

  typedef struct {
    logic [255:0] p;
    logic [127:0] r;
    int           due;
  } exp_t;

  exp_t         sb[$];
  int           tests = 0;
  int           fails = 0;
  int           cyc   = 0;
  logic         rst_at_edge = 1'b1;
  logic [255:0] last_p = 256'd0;
  logic [127:0] last_r = 128'd0;

  // Reference reduction: polynomial long division by x^128+x^7+x^2+x+1.
  function automatic logic [127:0] gf_mod(input logic [255:0] p);
    logic [255:0] rem;
    logic [255:0] poly;
    rem  = p;
    poly = (256'd1 << 128) | 256'h87;
    for (int i = 255; i >= 128; i--) begin
      if (rem[i]) rem = rem ^ (poly << (i - 128));
    end
    return rem[127:0];
  endfunction

  function automatic logic [255:0] int_mul(input logic [127:0] x, input logic [127:0] y);
    return {128'd0, x} * {128'd0, y};
  endfunction

  // Edge bookkeeping: count cycles and remember whether reset was sampled.
  always @(posedge clk) begin
    cyc         = cyc + 1;
    rst_at_edge = rst_n;
  end

  // Monitor: compare outputs on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (cyc > 0) begin
      while (sb.size() > 0 && sb[0].due < cyc) begin
        tests++; fails++;
        $display("FAIL missing_output: no out_valid at cycle %0d, required product=%h", sb[0].due, sb[0].p);
        void'(sb.pop_front());
      end
      if (!rst_at_edge) begin
        tests++;
        if (out_valid !== 1'b0 || product !== 256'd0 || reduced !== 128'd0) begin
          fails++;
          $display("FAIL reset_state: got out_valid=%b product=%h reduced=%h, required 0/0/0", out_valid, product, reduced);
        end
        last_p = 256'd0;
        last_r = 128'd0;
      end else if (out_valid === 1'b1) begin
        if (sb.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_valid: out_valid=1 at cycle %0d with no op pending, product=%h", cyc, product);
        end else begin
          exp_t e;
          e = sb.pop_front();
          tests++;
          if (e.due != cyc) begin
            fails++;
            $display("FAIL latency: result at cycle %0d, required cycle %0d", cyc, e.due);
          end
          tests++;
          if (product !== e.p) begin
            fails++;
            $display("FAIL product: got %h required %h", product, e.p);
          end
          tests++;
          if (reduced !== e.r) begin
            fails++;
            $display("FAIL reduced: got %h required %h", reduced, e.r);
          end
        end
        last_p = product;
        last_r = reduced;
      end else begin
        tests++;
        if (out_valid !== 1'b0 || product !== last_p || reduced !== last_r) begin
          fails++;
          $display("FAIL bubble_hold: got v=%b product=%h reduced=%h, required v=0 product=%h reduced=%h",
                   out_valid, product, reduced, last_p, last_r);
        end
      end
    end
  end

  // Issue one cycle of stimulus. Valid ops push the given expectations.
  task automatic drive(input logic v, input logic [127:0] aa, input logic [127:0] bb,
                       input logic [255:0] ep, input logic [127:0] er);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    in_valid = v;
    a        = aa;
    b        = bb;
    if (v) begin
      e.p   = ep;
      e.r   = er;
      e.due = cyc + 3;
      sb.push_back(e);
    end
  endtask

  task automatic op(input logic [127:0] aa, input logic [127:0] bb);
    logic [255:0] p;
    p = int_mul(aa, bb);
    drive(1'b1, aa, bb, p, gf_mod(p));
  endtask

  task automatic idle();
    drive(1'b0, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
          256'd0, 128'd0);
  endtask

  // Hold reset for n cycles while in_valid=1 drives garbage. Ops still in
  // flight are dropped, except one already due at the current cycle.
  task automatic do_reset(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      rst_n    = 1'b0;
      in_valid = 1'b1;
      a        = {$urandom, $urandom, $urandom, $urandom};
      b        = {$urandom, $urandom, $urandom, $urandom};
      for (int j = sb.size() - 1; j >= 0; j--) begin
        if (sb[j].due > cyc) sb.delete(j);
      end
    end
  endtask

  logic [127:0] ones;
  logic [127:0] ra;
  logic [127:0] rb;

  initial begin
    ones     = {128{1'b1}};
    rst_n    = 1'b0;
    in_valid = 1'b1;
    a        = 128'd0;
    b        = 128'd0;
    do_reset(3);

    // Directed corner cases, with spec-given constants where they exist.
    drive(1'b1, 128'd0, 128'd0, 256'd0, 128'd0);
    drive(1'b1, ones, ones, {{127{1'b1}}, 1'b0, 127'd0, 1'b1}, gf_mod(int_mul(ones, ones)));
    drive(1'b1, 128'd1 << 127, 128'd2, 256'd1 << 128, 128'h87);
    drive(1'b1, 128'd1, 128'd1, 256'd1, 128'd1);
    idle();

    // Six back-to-back ops.
    op({4{32'hAAAAAAAA}}, {4{32'h55555555}});
    op({4{32'hDEADBEEF}}, {4{32'hDEADBEEF}});
    op({4{32'h11111111}}, {4{32'h22222222}});
    op(128'hFEDCBA98_76543210_FEDCBA98_76543210, 128'h01234567_89ABCDEF_01234567_89ABCDEF);
    op(ones, 128'd1 << 127);
    op({64'd0, {64{1'b1}}}, {{64{1'b1}}, 64'd0});
    repeat (4) idle();

    // Bubble plus mid-reset: the second op is in flight when reset hits.
    op({4{32'h12345678}}, {4{32'h9ABCDEF0}});
    idle();
    op({4{32'hCAFEBABE}}, {4{32'h0BADF00D}});
    do_reset(1);
    repeat (3) idle();
    op({4{32'h31415926}}, {4{32'h27182818}});
    repeat (4) idle();

    // Randomized ops with occasional bubbles and extreme operands.
    for (int i = 0; i < 300; i++) begin
      ra = {$urandom, $urandom, $urandom, $urandom};
      rb = {$urandom, $urandom, $urandom, $urandom};
      case ($urandom_range(0, 7))
        0: ra = ones;
        1: rb = ones;
        2: ra = ra & {64'd0, {64{1'b1}}};
        3: rb = rb & {{64{1'b1}}, 64'd0};
        default: ra = ra;
      endcase
      if ($urandom_range(0, 3) == 0) idle();
      else op(ra, rb);
    end
    repeat (6) idle();

    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d ops still pending, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
